// File: rtl/control_fsm_pkg.sv
// control_fsm_pkg: opcodes, state encoding, ALU and immediate-extension codes for the control unit
package control_fsm_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_NANDI = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, EXEC_I, EXEC_CMP, MEM_ADDR,
    MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, SKIP
  } state_t;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_NAND = 4'b0101;
  localparam logic [1:0] IMM_SEXT = 2'b00;
  localparam logic [1:0] IMM_ZEXT = 2'b01;
  localparam logic [1:0] IMM_HI16 = 2'b10;
  localparam logic [1:0] IMM_BR   = 2'b11;
endpackage

// File: rtl/control_fsm_opcode_class.sv
// opcode_class: combinational opcode classifier
//   opcode in; rtype/ialu/branch_u/branch_c/load/store/illegal out (exactly one set)
module opcode_class
  import control_fsm_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       rtype,
  output logic       ialu,
  output logic       branch_u,
  output logic       branch_c,
  output logic       load,
  output logic       store,
  output logic       illegal
);
  assign rtype    = opcode == OP_RTYPE;
  assign ialu     = opcode inside {OP_LI, OP_LUI, OP_ADDI, OP_NANDI, OP_ORI};
  assign branch_u = opcode == OP_B;
  assign branch_c = opcode inside {OP_BEQ, OP_BNE};
  assign load     = opcode inside {OP_LW, OP_LB};
  assign store    = opcode inside {OP_SW, OP_SB};
  assign illegal  = !(rtype || ialu || branch_u || branch_c || load || store);
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multicycle control unit sequencing fetch/decode/execute/memory/write-back
//   Clk, Reset (async, active-high); Instr, Zero in
//   IR_LdEn, PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel,
//   ALU_func, ImmExt, MEM_WrEn, ByteOp, Illegal out (all registered)
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int FUNC_W  = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [INSTR_W-1:0] Instr,
  input  logic               Zero,
  output logic               IR_LdEn,
  output logic               PC_Sel,
  output logic               PC_LdEn,
  output logic               RF_WrEn,
  output logic               RF_WrData_sel,
  output logic               RF_B_sel,
  output logic               ALU_Bin_sel,
  output logic [FUNC_W-1:0]  ALU_func,
  output logic [1:0]         ImmExt,
  output logic               MEM_WrEn,
  output logic               ByteOp,
  output logic               Illegal
);
  state_t state, nxt;
  logic [5:0] opcode_q, op;
  logic [FUNC_W-1:0] func_q, fn;
  logic rtype, ialu, branch_u, branch_c, load, store, illegal;
  logic act, term;
  logic unused_bits;
  // While leaving FETCH the live word decides the DECODE-cycle outputs; afterwards only the captured copy counts
  assign op = state == FETCH ? Instr[INSTR_W-1 -: 6] : opcode_q;
  assign fn = state == FETCH ? Instr[FUNC_W-1:0] : func_q;
  assign unused_bits = ^Instr[INSTR_W-7:FUNC_W];
  opcode_class u_class (
    .opcode(op), .rtype(rtype), .ialu(ialu), .branch_u(branch_u),
    .branch_c(branch_c), .load(load), .store(store), .illegal(illegal)
  );
  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:    nxt = DECODE;
      DECODE:   nxt = rtype ? EXEC_R : ialu ? EXEC_I : branch_u ? BRANCH :
                      branch_c ? EXEC_CMP : illegal ? SKIP : MEM_ADDR;
      EXEC_R:   nxt = WB_ALU;
      EXEC_I:   nxt = WB_ALU;
      EXEC_CMP: nxt = BRANCH;
      MEM_ADDR: nxt = load ? MEM_RD : MEM_WR;
      MEM_RD:   nxt = WB_MEM;
      default:  nxt = FETCH;
    endcase
  end
  // Datapath selects are held for every cycle of an instruction after FETCH
  assign act  = nxt != FETCH;
  assign term = nxt inside {WB_ALU, WB_MEM, MEM_WR, BRANCH, SKIP};
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state         <= IDLE;
      opcode_q      <= '0;
      func_q        <= '0;
      IR_LdEn       <= 1'b0;
      PC_Sel        <= 1'b0;
      PC_LdEn       <= 1'b0;
      RF_WrEn       <= 1'b0;
      RF_WrData_sel <= 1'b0;
      RF_B_sel      <= 1'b0;
      ALU_Bin_sel   <= 1'b0;
      ALU_func      <= '0;
      ImmExt        <= '0;
      MEM_WrEn      <= 1'b0;
      ByteOp        <= 1'b0;
      Illegal       <= 1'b0;
    end else begin
      state <= nxt;
      if (state == FETCH) begin
        opcode_q <= op;
        func_q   <= fn;
      end
      IR_LdEn       <= nxt == FETCH;
      // Zero is only consulted on the edge out of EXEC_CMP, so it is frozen for the BRANCH cycle
      PC_Sel        <= nxt == BRANCH && (branch_u || (op == OP_BEQ ? Zero : !Zero));
      PC_LdEn       <= term;
      RF_WrEn       <= nxt inside {WB_ALU, WB_MEM};
      RF_WrData_sel <= act && load;
      RF_B_sel      <= act && (store || branch_c);
      ALU_Bin_sel   <= act && (ialu || load || store);
      ALU_func      <= !act ? '0 : rtype ? fn :
                       FUNC_W'(op == OP_NANDI ? ALU_NAND : op == OP_ORI ? ALU_OR :
                               branch_c ? ALU_SUB : ALU_ADD);
      ImmExt        <= !act ? IMM_SEXT : op inside {OP_NANDI, OP_ORI} ? IMM_ZEXT :
                       op == OP_LUI ? IMM_HI16 : (branch_u || branch_c) ? IMM_BR : IMM_SEXT;
      MEM_WrEn      <= nxt == MEM_WR;
      ByteOp        <= act && op inside {OP_LB, OP_SB};
      Illegal       <= nxt == SKIP;
    end
endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle control unit for the processor core. It consumes the 32-bit instruction word produced by the instruction fetch stage and sequences each instruction through fetch, decode, execute, memory and write-back states. Every cycle it drives the fetch stage's PC_Sel/PC_LdEn and the datapath's register-file, ALU, immediate and memory controls. It sits directly downstream of the fetch stage and closes the loop back into it.

## Interface
Parameters:
- INSTR_W, 32, instruction word width
- FUNC_W, 4, ALU function code width

Ports:
- Clk  in  1  system clock, all state changes on rising edge
- Reset  in  1  asynchronous, active-high; clears state and all outputs
- Instr  in  32  instruction word from the fetch stage; stable during FETCH
- Zero  in  1  ALU zero flag; sampled in EXEC_CMP
- IR_LdEn  out  1  datapath instruction register load
- PC_Sel  out  1  0 = PC+4, 1 = PC+4+branch offset
- PC_LdEn  out  1  PC load enable; exactly one pulse per instruction
- RF_WrEn  out  1  register file write enable
- RF_WrData_sel  out  1  0 = ALU result, 1 = memory data
- RF_B_sel  out  1  0 = read rt (Instr[15:11]), 1 = read rd (Instr[20:16])
- ALU_Bin_sel  out  1  0 = register B, 1 = immediate
- ALU_func  out  FUNC_W  ALU operation
- ImmExt  out  2  00 sign-extend, 01 zero-extend, 10 shift-left-16, 11 sign-extend then shift-left-2
- MEM_WrEn  out  1  data memory write enable
- ByteOp  out  1  1 for lb/sb
- Illegal  out  1  one-cycle pulse on an unknown opcode

## Operation
- The FSM captures opcode Instr[31:26] and func Instr[3:0] on the edge that leaves FETCH. Later Instr changes are ignored until the next FETCH.
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, EXEC_CMP, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, SKIP.
- Sequences by opcode:
  - R-type 100000: FETCH, DECODE, EXEC_R, WB_ALU.
  - li 111000, lui 111001, addi 110000, nandi 110010, ori 110011: FETCH, DECODE, EXEC_I, WB_ALU.
  - b 111111: FETCH, DECODE, BRANCH, with PC_Sel=1.
  - beq 000000 / bne 000001: FETCH, DECODE, EXEC_CMP, BRANCH. PC_Sel = Zero for beq, !Zero for bne.
  - lw 001111 / lb 000011: FETCH, DECODE, MEM_ADDR, MEM_RD, WB_MEM.
  - sw 011111 / sb 000111: FETCH, DECODE, MEM_ADDR, MEM_WR.
  - Any other opcode: FETCH, DECODE, SKIP. SKIP pulses Illegal=1 and PC_LdEn=1 with PC_Sel=0, so it behaves as a nop.
- IDLE always goes to FETCH. Every terminal state (WB_ALU, WB_MEM, MEM_WR, BRANCH, SKIP) goes to FETCH.
- PC_LdEn is asserted only in terminal states. RF_WrEn is asserted only in WB_ALU and WB_MEM. MEM_WrEn is asserted only in MEM_WR. IR_LdEn is asserted only in FETCH.
- ALU_func:
  - R-type: captured func.
  - add/li/lui/memory ops: 0000.
  - nandi: 0101.
  - ori: 0011.
  - beq/bne: 0001 (sub).
- ImmExt:
  - li, addi, memory ops: 00.
  - nandi, ori: 01.
  - lui: 10.
  - Branches: 11.
- RF_B_sel=1 for stores and beq/bne, 0 otherwise.
- ALU_Bin_sel=1 for I-type ALU ops and memory ops.

## Timing
- All outputs are registered. Each output is computed from the next state and the captured opcode, so it is valid for the whole cycle spent in a state. There is no combinational path from Instr or Zero to any output.
- Reset: state=IDLE, all outputs 0. Release gives IDLE for one cycle, then FETCH on the next edge.
- Reset asserted mid-instruction aborts it immediately, with no PC_LdEn, RF_WrEn or MEM_WrEn pulse. Restart is from IDLE.
- Instruction latency in cycles:
  - R-type and I-type: 4.
  - b and illegal: 3.
  - beq/bne: 4.
  - Load: 5.
  - Store: 4.
- Zero is sampled on the edge leaving EXEC_CMP. Zero changing inside BRANCH has no effect.
- Every instruction produces exactly one PC_LdEn pulse of one cycle.
- Write enables are never asserted simultaneously.

## Structure
- Shared package holds:
  - Opcode constants.
  - State enum encoding.
  - ALU function codes (ADD, SUB, OR, NAND).
  - ImmExt codes.
- One sub-module, opcode_class, is a combinational classifier: opcode to {rtype, ialu, branch_u, branch_c, load, store, illegal}. It is used by both the next-state and output logic.

## Test plan
- Reset held 3 cycles then released -> all outputs 0 during reset. IDLE then FETCH with IR_LdEn=1 on the second cycle after release.
- Instr=0x80221830 (R-type, func 110000) -> ALU_func=0000 in EXEC_R. RF_WrEn=1, PC_LdEn=1, PC_Sel=0 in cycle 4. PC_LdEn pulses exactly once.
- lw, opcode 001111 -> ALU_Bin_sel=1 and ImmExt=00 in MEM_ADDR. RF_WrData_sel=1, RF_WrEn=1, PC_LdEn=1 in cycle 5. MEM_WrEn stays 0.
- beq (000000), first with Zero=1 then with Zero=0 -> BRANCH shows PC_Sel=1 then PC_Sel=0, with PC_LdEn=1 both times. Toggling Zero during BRANCH changes nothing.
- Instr=0x08000000 (opcode 000010) -> SKIP in cycle 3 with Illegal=1, PC_LdEn=1, PC_Sel=0, RF_WrEn=0.
- sb (000111) with Reset asserted asynchronously in MEM_ADDR -> all outputs 0 immediately. No MEM_WrEn or PC_LdEn pulse occurs, and the FSM restarts at IDLE.
